// File: rtl/right_shifter_seq_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encodings
// and default datapath sizing.
package right_shifter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_AMTW  = 4;

endpackage

// File: rtl/right_shifter_seq.sv
// Sequential right shifter: one bit position per clock, logical or arithmetic,
// with a one-cycle done pulse once the requested count has been applied.
module right_shifter_seq
  import right_shifter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMTW  = DEFAULT_AMTW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMTW-1:0]  amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [AMTW-1:0]  cnt;
  logic             arith_r;

  // Single-position shift; fill bit is the sign only for arithmetic shifts.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic             a);
    return {a & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (amt == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == AMTW'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are captured only on an accepted start, so later input
  // changes and starts seen in SHIFT/DONE cannot disturb the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      arith_r <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            work    <= data_in;
            cnt     <= amt;
            arith_r <= arith;
          end
        end
        ST_SHIFT: begin
          work <= shift_one(work, arith_r);
          cnt  <= cnt - AMTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);
  assign result = work;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Self-checking bench for right_shifter_seq: directed cases, ignored starts,
// back-to-back operation, randomized operations and reset behaviour.
module tb_right_shifter_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [15:0] data_in;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  right_shifter_seq #(.WIDTH(16), .AMTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arith(arith),
    .data_in(data_in), .amt(amt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: floor division by 2^amt for signed operands, plain division otherwise.
  function automatic logic [15:0] model(input logic [15:0] d, input int a, input bit ar);
    longint p, sd, q;
    p = longint'(1) << a;
    if (ar) begin
      sd = longint'($signed(d));
      q  = sd / p;
      if (sd < 0 && (sd % p) != 0) q = q - 1;
    end else begin
      q = longint'(d) / p;
    end
    return q[15:0];
  endfunction

  // Runs one operation; inputs are scrambled after the capture edge.
  task automatic do_op(input logic [15:0] d, input logic [3:0] a, input logic ar,
                       output logic [15:0] res, output int lat, output int busy_cnt,
                       output int done_cnt, output bit both);
    res = 16'h0; lat = -1; busy_cnt = 0; done_cnt = 0; both = 0;
    @(negedge clk);
    start = 1'b1; data_in = d; amt = a; arith = ar;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start   = 1'b0;
      data_in = 16'($urandom);
      amt     = 4'($urandom);
      arith   = 1'($urandom);
      if (busy) busy_cnt++;
      if (busy && done) both = 1;
      if (done) begin
        if (done_cnt == 0) begin lat = i; res = result; end
        done_cnt++;
      end
      if (lat >= 0 && i > lat + 2) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; arith = 1'b0; data_in = '0; amt = '0;
    #2;
    total++;
    if ({busy, done, result} !== 18'h0) begin
      bad++; $display("FAIL reset_async: busy=%b done=%b result=%h want all 0", busy, done, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, result} !== 18'h0) begin
      bad++; $display("FAIL reset_held: busy=%b done=%b result=%h want all 0", busy, done, result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] d_t[6]  = '{16'd48, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h1234};
    logic [3:0]  a_t[6]  = '{4'd2, 4'd3, 4'd3, 4'd15, 4'd15, 4'd0};
    logic        ar_t[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] e_t[6]  = '{16'd12, 16'hF000, 16'h1000, 16'hFFFF, 16'h0001, 16'h1234};
    logic [15:0] res;
    int lat, bc, dc;
    bit both;
    for (int k = 0; k < 6; k++) begin
      do_op(d_t[k], a_t[k], ar_t[k], res, lat, bc, dc, both);
      total++;
      if (res !== e_t[k]) begin
        bad++; $display("FAIL dir%0d_result: got %h want %h", k, res, e_t[k]);
      end
      total++;
      if (lat != int'(a_t[k])) begin
        bad++; $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, a_t[k]);
      end
      total++;
      if (bc != int'(a_t[k]) || dc != 1 || both) begin
        bad++; $display("FAIL dir%0d_handshake: busy_cycles=%0d done_pulses=%0d overlap=%0d want %0d/1/0",
                        k, bc, dc, both, a_t[k]);
      end
      total++;
      if (result !== e_t[k]) begin
        bad++; $display("FAIL dir%0d_hold: got %h want %h", k, result, e_t[k]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [15:0] exp_v;
    int lat, dc;
    exp_v = model(16'h0F0F, 5, 1'b1);
    lat = -1; dc = 0;
    @(negedge clk);
    start = 1'b1; data_in = 16'h0F0F; amt = 4'd5; arith = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1 || done) begin
        start = 1'b1; data_in = 16'hFFFF; amt = 4'd1; arith = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        if (dc == 0) lat = i;
        dc++;
      end
      if (lat >= 0 && i > lat + 3) break;
    end
    start = 1'b0;
    total++;
    if (dc != 1 || lat != 5) begin
      bad++; $display("FAIL ignored_start_done: pulses=%0d latency=%0d want 1/5", dc, lat);
    end
    total++;
    if (result !== exp_v) begin
      bad++; $display("FAIL ignored_start_result: got %h want %h", result, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d_q[3];
    logic [3:0]  a_q[3];
    logic        ar_q[3];
    int k, prev, want_idx;
    bit load_next;
    for (int j = 0; j < 3; j++) begin
      d_q[j] = 16'($urandom); a_q[j] = 4'($urandom_range(6, 0)); ar_q[j] = 1'($urandom);
    end
    k = 0; prev = 0; load_next = 0;
    @(negedge clk);
    start = 1'b1; data_in = d_q[0]; amt = a_q[0]; arith = ar_q[0];
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load_next) begin
        data_in = d_q[k]; amt = a_q[k]; arith = ar_q[k]; load_next = 0;
      end
      if (done) begin
        want_idx = (k == 0) ? int'(a_q[0]) : prev + 2 + int'(a_q[k]);
        total++;
        if (result !== model(d_q[k], a_q[k], ar_q[k]) || i != want_idx) begin
          bad++; $display("FAIL b2b%0d: result=%h at %0d want %h at %0d", k, result, i,
                          model(d_q[k], a_q[k], ar_q[k]), want_idx);
        end
        prev = i;
        k++;
        if (k == 3) break;
        load_next = 1;
      end
    end
    start = 1'b0;
    total++;
    if (k != 3) begin
      bad++; $display("FAIL b2b_count: got %0d ops want 3", k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] d, res, exp_v;
    logic [3:0]  a;
    logic        ar;
    int lat, bc, dc;
    bit both;
    for (int k = 0; k < 24; k++) begin
      d = 16'($urandom); a = 4'($urandom_range(15, 0)); ar = 1'($urandom);
      if (k < 4) d[15] = 1'b1;
      exp_v = model(d, a, ar);
      do_op(d, a, ar, res, lat, bc, dc, both);
      total++;
      if (res !== exp_v || lat != int'(a) || bc != int'(a) || dc != 1 || both) begin
        bad++; $display("FAIL rand%0d: d=%h amt=%0d ar=%0d got %h lat=%0d busy=%0d pulses=%0d want %h lat=%0d",
                        k, d, a, ar, res, lat, bc, dc, exp_v, a);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res;
    int lat, bc, dc;
    bit both, saw_done;
    @(negedge clk);
    start = 1'b1; data_in = 16'hABCD; amt = 4'd10; arith = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_precond: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result} !== 18'h0) begin
      bad++; $display("FAIL rst_mid_async: busy=%b done=%b result=%h want all 0", busy, done, result);
    end
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++; $display("FAIL rst_mid_no_done: done pulse seen=1 want 0");
    end
    do_op(16'h00F0, 4'd4, 1'b0, res, lat, bc, dc, both);
    total++;
    if (res !== 16'h000F || lat != 4 || dc != 1) begin
      bad++; $display("FAIL rst_after_op: got %h lat=%0d pulses=%0d want 000f lat=4 pulses=1", res, lat, dc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
